// File: rtl/ctrl_pkg.sv
// Shared definitions for the accumulator-machine control unit: state
// encoding, opcode values and the datapath select encodings.
package ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int OP_W    = 5;

    // FSM states; codes 5..7 are never entered and fall back to fetch
    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM    = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Instruction opcodes
    localparam logic [OP_W-1:0] OP_HLT  = 5'b00000;
    localparam logic [OP_W-1:0] OP_STO  = 5'b00001;
    localparam logic [OP_W-1:0] OP_LD   = 5'b00010;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00011;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00100;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00110;
    localparam logic [OP_W-1:0] OP_SUBI = 5'b00111;
    localparam logic [OP_W-1:0] OP_BEQ  = 5'b01000;
    localparam logic [OP_W-1:0] OP_JMP  = 5'b01001;

    // ACC source select
    localparam logic [1:0] ACC_SEL_ALU = 2'b00;
    localparam logic [1:0] ACC_SEL_MEM = 2'b01;
    localparam logic [1:0] ACC_SEL_IMM = 2'b10;

    // ALU operation
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    // PC source select
    localparam logic PC_SEL_INC = 1'b0;
    localparam logic PC_SEL_IR  = 1'b1;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode-class decode. Classifies the IR opcode so the FSM
// only has to reason about instruction classes, not individual opcodes.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = 5
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    is_mem_rd,
    output logic                    is_mem_wr,
    output logic                    is_imm,
    output logic                    is_branch,
    output logic                    is_cond,
    output logic                    is_halt,
    output logic [1:0]              alu_op,
    output logic [1:0]              acc_sel
);

    // Opcode constants resized to the configured field width
    localparam logic [OPCODE_WIDTH-1:0] C_HLT  = OPCODE_WIDTH'(OP_HLT);
    localparam logic [OPCODE_WIDTH-1:0] C_STO  = OPCODE_WIDTH'(OP_STO);
    localparam logic [OPCODE_WIDTH-1:0] C_LD   = OPCODE_WIDTH'(OP_LD);
    localparam logic [OPCODE_WIDTH-1:0] C_LDI  = OPCODE_WIDTH'(OP_LDI);
    localparam logic [OPCODE_WIDTH-1:0] C_ADD  = OPCODE_WIDTH'(OP_ADD);
    localparam logic [OPCODE_WIDTH-1:0] C_ADDI = OPCODE_WIDTH'(OP_ADDI);
    localparam logic [OPCODE_WIDTH-1:0] C_SUB  = OPCODE_WIDTH'(OP_SUB);
    localparam logic [OPCODE_WIDTH-1:0] C_SUBI = OPCODE_WIDTH'(OP_SUBI);
    localparam logic [OPCODE_WIDTH-1:0] C_BEQ  = OPCODE_WIDTH'(OP_BEQ);
    localparam logic [OPCODE_WIDTH-1:0] C_JMP  = OPCODE_WIDTH'(OP_JMP);

    // Class flags and ACC/ALU selects per opcode; unknown opcodes decode as NOP
    always_comb begin
        is_mem_rd = 1'b0;
        is_mem_wr = 1'b0;
        is_imm    = 1'b0;
        is_branch = 1'b0;
        is_cond   = 1'b0;
        is_halt   = 1'b0;
        alu_op    = ALU_ADD;
        acc_sel   = ACC_SEL_ALU;
        case (opcode)
            C_HLT: begin
                is_halt = 1'b1;
            end
            C_STO: begin
                is_mem_wr = 1'b1;
            end
            C_LD: begin
                is_mem_rd = 1'b1;
                acc_sel   = ACC_SEL_MEM;
            end
            C_ADD: begin
                is_mem_rd = 1'b1;
                alu_op    = ALU_ADD;
            end
            C_SUB: begin
                is_mem_rd = 1'b1;
                alu_op    = ALU_SUB;
            end
            C_LDI: begin
                is_imm  = 1'b1;
                acc_sel = ACC_SEL_IMM;
            end
            C_ADDI: begin
                is_imm = 1'b1;
                alu_op = ALU_ADD;
            end
            C_SUBI: begin
                is_imm = 1'b1;
                alu_op = ALU_SUB;
            end
            C_JMP: begin
                is_branch = 1'b1;
            end
            C_BEQ: begin
                is_branch = 1'b1;
                is_cond   = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle control FSM for the accumulator datapath: fetch, decode,
// optional memory access with ready handshake, optional ACC write.
// All outputs are held at zero while reset is asserted so that an
// aborted instruction never commits a partial write.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = 5,
    parameter int STATE_WIDTH  = 3
) (
    input  logic                    clock,
    input  logic                    ctrl_reset_n,
    input  logic [OPCODE_WIDTH-1:0] ctrl_opcode,
    input  logic                    ctrl_zero,
    input  logic                    ctrl_mem_ready,
    output logic                    ctrl_mem_rd,
    output logic                    ctrl_mem_wr,
    output logic                    ctrl_pc_wr,
    output logic                    ctrl_pc_sel,
    output logic                    ctrl_ir_wr,
    output logic                    ctrl_acc_wr,
    output logic [1:0]              ctrl_acc_sel,
    output logic [1:0]              ctrl_alu_op,
    output logic                    ctrl_halted,
    output logic [STATE_WIDTH-1:0]  ctrl_state
);

    state_t state_reg;
    state_t state_next;

    logic       is_mem_rd;
    logic       is_mem_wr;
    logic       is_imm;
    logic       is_branch;
    logic       is_cond;
    logic       is_halt;
    logic [1:0] dec_alu_op;
    logic [1:0] dec_acc_sel;

    // Ungated control values, before the reset override
    logic       mem_rd_raw;
    logic       mem_wr_raw;
    logic       pc_wr_raw;
    logic       pc_sel_raw;
    logic       ir_wr_raw;
    logic       acc_wr_raw;
    logic [1:0] acc_sel_raw;
    logic [1:0] alu_op_raw;
    logic       halted_raw;

    ctrl_decoder #(
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_decoder (
        .opcode    (ctrl_opcode),
        .is_mem_rd (is_mem_rd),
        .is_mem_wr (is_mem_wr),
        .is_imm    (is_imm),
        .is_branch (is_branch),
        .is_cond   (is_cond),
        .is_halt   (is_halt),
        .alu_op    (dec_alu_op),
        .acc_sel   (dec_acc_sel)
    );

    // State register: reset takes effect immediately, returning to fetch
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; memory ready only matters in fetch and mem
    always_comb begin
        state_next = ST_FETCH;
        case (state_reg)
            ST_FETCH: begin
                state_next = ctrl_mem_ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                if (is_halt) begin
                    state_next = ST_HALT;
                end else if (is_mem_rd || is_mem_wr) begin
                    state_next = ST_MEM;
                end else if (is_imm) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (!(is_mem_rd || is_mem_wr)) begin
                    // IR is stable here, so this only guards against misuse
                    state_next = ST_FETCH;
                end else if (!ctrl_mem_ready) begin
                    state_next = ST_MEM;
                end else if (is_mem_wr) begin
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Output decode from state, opcode class, memory ready and zero flag
    always_comb begin
        mem_rd_raw  = 1'b0;
        mem_wr_raw  = 1'b0;
        pc_wr_raw   = 1'b0;
        pc_sel_raw  = PC_SEL_INC;
        ir_wr_raw   = 1'b0;
        acc_wr_raw  = 1'b0;
        acc_sel_raw = ACC_SEL_ALU;
        alu_op_raw  = ALU_ADD;
        halted_raw  = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                mem_rd_raw = 1'b1;
                if (ctrl_mem_ready) begin
                    ir_wr_raw  = 1'b1;
                    pc_wr_raw  = 1'b1;
                    pc_sel_raw = PC_SEL_INC;
                end
            end
            ST_DECODE: begin
                if (is_branch) begin
                    pc_sel_raw = PC_SEL_IR;
                    pc_wr_raw  = is_cond ? ctrl_zero : 1'b1;
                end
            end
            ST_MEM: begin
                // Request held for every cycle of the handshake
                mem_wr_raw = is_mem_wr;
                mem_rd_raw = is_mem_rd && !is_mem_wr;
            end
            ST_EXEC: begin
                acc_wr_raw  = 1'b1;
                acc_sel_raw = dec_acc_sel;
                alu_op_raw  = dec_alu_op;
            end
            ST_HALT: begin
                halted_raw = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset override: every output reads zero while reset is low
    assign ctrl_mem_rd  = ctrl_reset_n & mem_rd_raw;
    assign ctrl_mem_wr  = ctrl_reset_n & mem_wr_raw;
    assign ctrl_pc_wr   = ctrl_reset_n & pc_wr_raw;
    assign ctrl_pc_sel  = ctrl_reset_n & pc_sel_raw;
    assign ctrl_ir_wr   = ctrl_reset_n & ir_wr_raw;
    assign ctrl_acc_wr  = ctrl_reset_n & acc_wr_raw;
    assign ctrl_acc_sel = {2{ctrl_reset_n}} & acc_sel_raw;
    assign ctrl_alu_op  = {2{ctrl_reset_n}} & alu_op_raw;
    assign ctrl_halted  = ctrl_reset_n & halted_raw;
    assign ctrl_state   = {STATE_WIDTH{ctrl_reset_n}} & STATE_WIDTH'(state_reg);

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: the stimulus process pushes the
// hand-computed output vector for each cycle, and a monitor on the falling
// edge pops and compares it against the DUT outputs.
module tb_ctrl_unit;

    logic       clock;
    logic       rst_n;
    logic [4:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_rd;
    logic       mem_wr;
    logic       pc_wr;
    logic       pc_sel;
    logic       ir_wr;
    logic       acc_wr;
    logic [1:0] acc_sel;
    logic [1:0] alu_op;
    logic       halted;
    logic [2:0] state;

    logic [13:0] act;

    typedef struct {
        logic [13:0] vec;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   compared;
    int   mismatched;

    ctrl_unit #(
        .OPCODE_WIDTH (5),
        .STATE_WIDTH  (3)
    ) dut (
        .clock          (clock),
        .ctrl_reset_n   (rst_n),
        .ctrl_opcode    (opcode),
        .ctrl_zero      (zero),
        .ctrl_mem_ready (mem_ready),
        .ctrl_mem_rd    (mem_rd),
        .ctrl_mem_wr    (mem_wr),
        .ctrl_pc_wr     (pc_wr),
        .ctrl_pc_sel    (pc_sel),
        .ctrl_ir_wr     (ir_wr),
        .ctrl_acc_wr    (acc_wr),
        .ctrl_acc_sel   (acc_sel),
        .ctrl_alu_op    (alu_op),
        .ctrl_halted    (halted),
        .ctrl_state     (state)
    );

    assign act = {mem_rd, mem_wr, pc_wr, pc_sel, ir_wr, acc_wr,
                  acc_sel, alu_op, halted, state};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected vector: rd, wr, pc_wr, pc_sel, ir_wr, acc_wr, acc_sel, alu_op, halted, state
    function automatic logic [13:0] ev(input logic rd, input logic wr,
                                       input logic pcw, input logic pcs,
                                       input logic irw, input logic accw,
                                       input logic [1:0] accs, input logic [1:0] alu,
                                       input logic h, input logic [2:0] st);
        return {rd, wr, pcw, pcs, irw, accw, accs, alu, h, st};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected during it
    task automatic step(input logic rst, input logic [4:0] op, input logic z,
                        input logic rdy, input logic [13:0] exp_v, input string tag);
        exp_t e;
        rst_n     = rst;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        e.vec     = exp_v;
        e.tag     = tag;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare each queued expectation mid-cycle
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compared++;
            if (act !== e.vec) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b", e.tag, act, e.vec);
            end else begin
                $display("ok   %s: %b", e.tag, act);
            end
        end
    end

    initial begin
        logic [13:0] v_zero;
        logic [13:0] v_fwait;
        logic [13:0] v_fgo;
        logic [13:0] v_dec;
        logic [13:0] v_halt;

        compared   = 0;
        mismatched = 0;
        v_zero  = ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd0);
        v_fwait = ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd0);
        v_fgo   = ev(1, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'd0);
        v_dec   = ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd1);
        v_halt  = ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 3'd4);

        rst_n     = 1'b0;
        opcode    = 5'b00000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clock);
        #1;

        // Reset held 3 cycles, then first cycle after release
        for (int i = 0; i < 3; i++) step(0, 5'b00011, 1, 1, v_zero, "reset");
        step(1, 5'b00011, 0, 0, v_fwait, "post_reset_fetch");

        // LDI with ready high
        step(1, 5'b00011, 0, 1, v_fgo, "ldi_fetch");
        step(1, 5'b00011, 0, 0, v_dec, "ldi_decode");
        step(1, 5'b00011, 0, 1, ev(0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'd3), "ldi_exec");

        // Fetch with 4 wait cycles, then JMP
        for (int i = 0; i < 4; i++) step(1, 5'b01001, 0, 0, v_fwait, "fetch_wait");
        step(1, 5'b01001, 0, 1, v_fgo, "jmp_fetch");
        step(1, 5'b01001, 0, 0, ev(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 3'd1), "jmp_decode");

        // BEQ taken and not taken
        step(1, 5'b01000, 0, 1, v_fgo, "beq1_fetch");
        step(1, 5'b01000, 1, 1, ev(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 3'd1), "beq_taken");
        step(1, 5'b01000, 0, 1, v_fgo, "beq0_fetch");
        step(1, 5'b01000, 0, 1, ev(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 3'd1), "beq_not_taken");

        // STO with 2 wait cycles in MEM
        step(1, 5'b00001, 0, 1, v_fgo, "sto_fetch");
        step(1, 5'b00001, 0, 1, v_dec, "sto_decode");
        step(1, 5'b00001, 0, 0, ev(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2), "sto_mem_wait");
        step(1, 5'b00001, 0, 0, ev(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2), "sto_mem_wait");
        step(1, 5'b00001, 0, 1, ev(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2), "sto_mem_ack");
        step(1, 5'b00100, 0, 0, v_fwait, "sto_back_to_fetch");

        // ADD, LD, SUBI, NOP
        step(1, 5'b00100, 0, 1, v_fgo, "add_fetch");
        step(1, 5'b00100, 0, 0, v_dec, "add_decode");
        step(1, 5'b00100, 0, 1, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2), "add_mem");
        step(1, 5'b00100, 0, 0, ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'd3), "add_exec");
        step(1, 5'b00010, 0, 1, v_fgo, "ld_fetch");
        step(1, 5'b00010, 0, 1, v_dec, "ld_decode");
        step(1, 5'b00010, 0, 1, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2), "ld_mem");
        step(1, 5'b00010, 0, 1, ev(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 3'd3), "ld_exec");
        step(1, 5'b00111, 0, 1, v_fgo, "subi_fetch");
        step(1, 5'b00111, 0, 1, v_dec, "subi_decode");
        step(1, 5'b00111, 0, 1, ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 3'd3), "subi_exec");
        step(1, 5'b01111, 0, 1, v_fgo, "nop_fetch");
        step(1, 5'b01111, 1, 1, v_dec, "nop_decode");

        // SUB aborted by reset on the second MEM cycle
        step(1, 5'b00110, 0, 1, v_fgo, "sub_fetch");
        step(1, 5'b00110, 0, 1, v_dec, "sub_decode");
        step(1, 5'b00110, 0, 0, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2), "sub_mem_wait");
        step(0, 5'b00110, 0, 1, v_zero, "sub_reset_abort");
        step(1, 5'b00110, 0, 0, v_fwait, "sub_after_reset");

        // HLT is absorbing until reset
        step(1, 5'b00000, 0, 1, v_fgo, "hlt_fetch");
        step(1, 5'b00000, 0, 1, v_dec, "hlt_decode");
        for (int i = 0; i < 20; i++) begin
            step(1, 5'b00000, i[1], i[0], v_halt, "halted");
        end
        step(0, 5'b00000, 0, 1, v_zero, "halt_reset");
        step(1, 5'b00000, 0, 0, v_fwait, "halt_exit_fetch");

        // Every queued expectation must have been consumed by the monitor
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
- Multi-cycle control FSM for the accumulator datapath. It sequences the PC, IR and ACC registers (each an instance of the 11-bit register block with write enable) and the memory port.
- Each instruction runs through fetch, decode, an optional memory access, and an optional accumulator write.
- Memory accesses use a ready handshake, so a memory with wait states is supported.
- Sits between the instruction register opcode field and the datapath write/select controls.

Parameters:
OPCODE_WIDTH, 5, width of the opcode field of the instruction
STATE_WIDTH, 3, width of the debug state output

Ports:
clock  in  1  system clock, rising edge
ctrl_reset_n  in  1  asynchronous, active-low reset
ctrl_opcode  in  OPCODE_WIDTH  opcode field taken from the IR output
ctrl_zero  in  1  ACC == 0 flag from the datapath
ctrl_mem_ready  in  1  memory acknowledges the current read or write this cycle
ctrl_mem_rd  out  1  memory read request
ctrl_mem_wr  out  1  memory write request (data = ACC)
ctrl_pc_wr  out  1  PC write enable
ctrl_pc_sel  out  1  PC source: 0 = PC+1, 1 = IR operand
ctrl_ir_wr  out  1  IR write enable
ctrl_acc_wr  out  1  ACC write enable
ctrl_acc_sel  out  2  ACC source: 00 = ALU, 01 = memory data, 10 = IR operand
ctrl_alu_op  out  2  ALU operation: 00 = add, 01 = sub
ctrl_halted  out  1  high while in HALT
ctrl_state  out  STATE_WIDTH  current state, for debug

Behaviour:
- Interface decision: one clock, `clock`; reset is asynchronous and active-low, `ctrl_reset_n`.
- Reset:
  - The state register goes to FETCH immediately.
  - While ctrl_reset_n = 0, every output is forced to 0, including ctrl_state = 0.
  - A reset asserted mid-instruction aborts it: write pulses drop in the same cycle, and there is no partial commit.
- State encoding: FETCH = 0, DECODE = 1, MEM = 2, EXEC = 3, HALT = 4. Codes 5–7 are unreachable and recover to FETCH on the next edge.
- Output decode: outputs are combinational from state, opcode, ctrl_mem_ready and ctrl_zero. Any output not listed for a state is 0.
- FETCH:
  - ctrl_mem_rd = 1 for as long as the FSM stays in FETCH.
  - In the cycle ctrl_mem_ready = 1: ctrl_ir_wr = 1, ctrl_pc_wr = 1, ctrl_pc_sel = 0, and next state is DECODE.
  - Otherwise the FSM stays in FETCH. There is no timeout.
- DECODE (always exactly one cycle), by opcode:
  - HLT 00000 → HALT.
  - STO 00001, LD 00010, ADD 00100, SUB 00110 → MEM.
  - LDI 00011, ADDI 00101, SUBI 00111 → EXEC.
  - JMP 01001: ctrl_pc_wr = 1, ctrl_pc_sel = 1 → FETCH.
  - BEQ 01000: ctrl_pc_wr = ctrl_zero, ctrl_pc_sel = 1 → FETCH.
  - Any other opcode is a NOP → FETCH.
- MEM:
  - STO: ctrl_mem_wr = 1 until ctrl_mem_ready = 1, then → FETCH.
  - LD, ADD, SUB: ctrl_mem_rd = 1 until ctrl_mem_ready = 1, then → EXEC.
- EXEC (one cycle, ctrl_acc_wr = 1, then → FETCH):
  - LD: ctrl_acc_sel = 01.
  - LDI: ctrl_acc_sel = 10.
  - ADD: ctrl_acc_sel = 00, ctrl_alu_op = 00.
  - SUB: ctrl_acc_sel = 00, ctrl_alu_op = 01.
  - ADDI, SUBI: ctrl_acc_sel = 00 with the same ctrl_alu_op as ADD/SUB. The datapath selects the operand.
- HALT: ctrl_halted = 1. This state is absorbing; only reset exits it.
- Mutual exclusion:
  - ctrl_mem_rd and ctrl_mem_wr are never high together.
  - ctrl_acc_wr is never high in the same cycle as ctrl_ir_wr.
  - ctrl_mem_ready is ignored outside FETCH and MEM.
- ctrl_opcode is sampled only in DECODE, MEM and EXEC. The IR holds it stable there because ctrl_ir_wr = 0.
- Latency with ctrl_mem_ready tied to 1:
  - JMP, BEQ, NOP: 2 cycles.
  - Immediate ops and STO: 3 cycles.
  - LD, ADD, SUB: 4 cycles.
  - Each memory wait cycle adds 1.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum (STATE_WIDTH bits);
  - the opcode localparams;
  - the acc_sel and alu_op encodings as named constants.
- Sub-module ctrl_decoder is natural. It is a combinational opcode-class decode (is_mem_rd, is_mem_wr, is_imm, is_branch, is_halt, alu_op). The FSM stays in ctrl_unit.

Test Plan:
- Reset: hold ctrl_reset_n = 0 for 3 cycles, then release → all outputs 0 with ctrl_state = 0 during reset; ctrl_mem_rd = 1 on the first cycle after release.
- LDI (00011), ready tied 1:
  - cycle 1: ir_wr = pc_wr = 1;
  - cycle 2: state = 1, no writes;
  - cycle 3: acc_wr = 1, acc_sel = 10;
  - cycle 4: state = 0.
- FETCH wait states, ctrl_mem_ready low for 4 cycles → mem_rd high for 5 cycles; ir_wr and pc_wr each pulse exactly once, on the ready cycle.
- BEQ (01000):
  - with zero = 1, DECODE gives pc_wr = 1, pc_sel = 1;
  - repeat with zero = 0, DECODE gives pc_wr = 0;
  - both cases → FETCH next cycle.
- STO (00001), ready low for 2 cycles in MEM → mem_wr high for 3 cycles, acc_wr never high, mem_rd low throughout MEM, then FETCH.
- SUB (00110), with reset asserted on the 2nd MEM cycle → all outputs 0 in that same cycle; after release, FETCH with no acc_wr. Separately, HLT (00000) → halted = 1 for 20 cycles until reset.
